key_event_proc: RTL and testbench
=================================

# key_event_proc

Parametrised multi-key front end. It synchronises and debounces N active-low push-buttons, then classifies each press as short, long or auto-repeat. It keeps a mode register selected by key index and emits single-`clk`-cycle event pulses. It replaces the fixed 4-key, `clk_100`-domain key handling: every output is registered in the `clk` domain, and all timing comes from an internal clock-enable tick, with no derived clock.

## Interface
- `NUM_KEYS`, 4, number of keys (1..16).
- `CLK_HZ`, 50_000_000, `clk` frequency.
- `SCAN_HZ`, 100, scan tick rate. `DIV = CLK_HZ/SCAN_HZ`, which must be ≥ 2.
- `DEBOUNCE_TICKS`, 2, consecutive equal samples needed to change the debounced level (≥ 1).
- `LONG_TICKS`, 100, hold time in ticks before a long event (> `DEBOUNCE_TICKS`).
- `REPEAT_TICKS`, 20, auto-repeat period in ticks after a long event (≥ 1).
- `WRITE_KEY`, 0, index of the key that generates `write_pulse`.
- `MODE_W`, derived as `max(1, clog2(NUM_KEYS))`.

Ports:
- `clk`, in, 1, system clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `key_in`, in, `NUM_KEYS`, raw key inputs, active low (0 = pressed), asynchronous to `clk`.
- `key_level`, out, `NUM_KEYS`, debounced level, 1 = pressed.
- `press_pulse`, out, `NUM_KEYS`, 1-cycle pulse per key on debounced press.
- `short_pulse`, out, `NUM_KEYS`, 1-cycle pulse on release when no long event occurred.
- `long_pulse`, out, `NUM_KEYS`, 1-cycle pulse when the hold reaches `LONG_TICKS`.
- `repeat_pulse`, out, `NUM_KEYS`, 1-cycle pulse every `REPEAT_TICKS` while held after a long event.
- `mode`, out, `MODE_W`, index of the last pressed key.
- `write_pulse`, out, 1, equals `press_pulse[WRITE_KEY]`, registered.

## Operation
- **Synchroniser:** a 2-flop synchroniser per key, reset to 1 (released).
- **Tick generator:** counter 0..`DIV`-1. `tick` is high for one `clk` cycle when the counter equals `DIV`-1, then the counter wraps to 0.
- **Debounce (on `tick` only):** per key, if the synchronised sample differs from `key_level`, increment the stability counter, otherwise clear it. When the counter reaches `DEBOUNCE_TICKS`, toggle `key_level` and clear the counter. A bounce shorter than `DEBOUNCE_TICKS` ticks never changes the level.
- **Per-key FSM (IDLE, HELD, LONG), with hold counter `hcnt`:**
  - IDLE → HELD on a debounced press: `press_pulse` fires and `hcnt` is cleared.
  - HELD: `hcnt` increments each tick. When `hcnt` reaches `LONG_TICKS`-1 and the key is still pressed, `long_pulse` fires, `hcnt` is cleared and the FSM goes to LONG. A debounced release before that fires `short_pulse` and returns to IDLE.
  - LONG: `hcnt` increments each tick. When `hcnt` reaches `REPEAT_TICKS`-1, `repeat_pulse` fires and `hcnt` is cleared. A release returns to IDLE with no `short_pulse`.
- **Counter width:** `hcnt` is `clog2(max(LONG_TICKS, REPEAT_TICKS))` bits. It never exceeds its terminal value, so it does not wrap.
- **Mode:** on any `press_pulse`, `mode` takes the lowest index among the keys pressing in that cycle. If no key presses, `mode` holds.
- **Independence:** keys are fully independent. Simultaneous holds give independent long/repeat streams.
- **Reset (asynchronous, any time, including mid-press):** all FSMs go to IDLE, every counter clears, `key_level` = 0, `mode` = 0, and all pulse outputs = 0. A key held through reset release is first seen as a press after debounce.

## Timing
- All outputs are registered. Every pulse is exactly one `clk` cycle wide, asserted in the cycle after the `tick` that caused it.
- **Press latency** from a `key_in` fall that stays stable: 2 `clk` (sync) + `DEBOUNCE_TICKS` ticks (± 1 tick of phase) + 1 `clk`.
- **Long event:** `LONG_TICKS` ticks after `press_pulse`.
- **First repeat:** `REPEAT_TICKS` ticks after `long_pulse`, then periodic with the same period.
- **Ordering:** no two events of the same key fire in the same cycle.
- **Write pulse:** `write_pulse` coincides with `press_pulse[WRITE_KEY]`. `mode` updates in the same cycle as `press_pulse`.

## Test plan
Parameters for all tests: `CLK_HZ`=1000, `SCAN_HZ`=100 (`DIV`=10), `DEBOUNCE_TICKS`=2, `LONG_TICKS`=10, `REPEAT_TICKS`=3, `NUM_KEYS`=4.

1. **Reset values:** assert `rst_n`=0 with `key_in`=4'hF. Require all outputs 0 and `mode`=0; after release, no pulses.
2. **Short press:** hold key 2 low for 50 `clk`, then release.
   - Require `press_pulse[2]` once, `mode`=2, `short_pulse[2]` once on release.
   - Require no `long_pulse` and no `write_pulse`.
3. **Long + repeat:** hold key 0 low for 200 `clk`.
   - Require `press_pulse[0]` and `write_pulse` once, `mode`=0.
   - Require `long_pulse[0]` exactly 100 `clk` after the press pulse.
   - Require `repeat_pulse[0]` every 30 `clk` thereafter (3 pulses within the window).
   - Require no `short_pulse` on release.
4. **Bounce rejection:** toggle key 1 low for 12 `clk` then high, 5 times. Require no change to `key_level` and no pulses.
5. **Simultaneous press:** drive keys 3 and 1 low in the same `clk`. Require `press_pulse`=4'b1010 in one cycle and `mode`=1.
6. **Reset mid-hold:** assert `rst_n` while key 3 is in LONG. Require all outputs 0 immediately (asynchronously). While the key stays held after reset release, require a new `press_pulse[3]` after debounce, and no `short_pulse`.

Source files
------------

// File: rtl/key_event_proc.sv
// Multi-key front end: synchronise, debounce and classify active-low buttons into
// press / short / long / auto-repeat pulses, all paced by one internal scan tick.
module key_event_proc #(
    parameter int NUM_KEYS       = 4,
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 100,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int LONG_TICKS     = 100,
    parameter int REPEAT_TICKS   = 20,
    parameter int WRITE_KEY      = 0,
    localparam int MODE_W        = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] short_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] repeat_pulse,
    output logic [MODE_W-1:0]   mode,
    output logic                write_pulse
);
    localparam int DIV    = CLK_HZ / SCAN_HZ;
    localparam int DIV_W  = $clog2(DIV);
    localparam int HMAX   = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HCNT_W = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] lvl_nxt, press_ev, short_ev, long_ev, rep_ev;
    logic [MODE_W-1:0]   mode_nxt;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sync1   <= '1;
            sync2   <= '1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            sync1   <= key_in;
            sync2   <= sync1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
        logic [HCNT_W-1:0] hcnt, hcnt_nxt;
        state_t            state, state_nxt;
        logic              lvl_k;
        logic              press_k, short_k, long_k, rep_k;

        // Debounce: the level flips only after DEBOUNCE_TICKS consecutive differing samples.
        always_comb begin
            db_cnt_nxt = db_cnt;
            lvl_k      = key_level[k];
            if (tick) begin
                if (~sync2[k] != key_level[k]) begin
                    if (db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
                        lvl_k      = ~key_level[k];
                        db_cnt_nxt = '0;
                    end else begin
                        db_cnt_nxt = db_cnt + 1'b1;
                    end
                end else begin
                    db_cnt_nxt = '0;
                end
            end
        end

        // The FSM acts on the level being committed this tick, so events and
        // key_level register on the same edge.
        always_comb begin
            state_nxt = state;
            hcnt_nxt  = hcnt;
            press_k   = 1'b0;
            short_k   = 1'b0;
            long_k    = 1'b0;
            rep_k     = 1'b0;
            if (tick) begin
                case (state)
                    IDLE: if (lvl_k) begin
                        press_k   = 1'b1;
                        hcnt_nxt  = '0;
                        state_nxt = HELD;
                    end
                    HELD: if (!lvl_k) begin
                        short_k   = 1'b1;
                        state_nxt = IDLE;
                    end else if (hcnt == HCNT_W'(LONG_TICKS - 1)) begin
                        long_k    = 1'b1;
                        hcnt_nxt  = '0;
                        state_nxt = LONG;
                    end else begin
                        hcnt_nxt  = hcnt + 1'b1;
                    end
                    LONG: if (!lvl_k) begin
                        state_nxt = IDLE;
                    end else if (hcnt == HCNT_W'(REPEAT_TICKS - 1)) begin
                        rep_k     = 1'b1;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt  = hcnt + 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                hcnt   <= '0;
                db_cnt <= '0;
            end else begin
                state  <= state_nxt;
                hcnt   <= hcnt_nxt;
                db_cnt <= db_cnt_nxt;
            end
        end

        assign lvl_nxt[k]  = lvl_k;
        assign press_ev[k] = press_k;
        assign short_ev[k] = short_k;
        assign long_ev[k]  = long_k;
        assign rep_ev[k]   = rep_k;
    end

    // Lowest pressing index wins when several keys press together.
    always_comb begin
        mode_nxt = mode;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_ev[i]) mode_nxt = MODE_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level    <= '0;
            press_pulse  <= '0;
            short_pulse  <= '0;
            long_pulse   <= '0;
            repeat_pulse <= '0;
            mode         <= '0;
            write_pulse  <= 1'b0;
        end else begin
            key_level    <= lvl_nxt;
            press_pulse  <= press_ev;
            short_pulse  <= short_ev;
            long_pulse   <= long_ev;
            repeat_pulse <= rep_ev;
            mode         <= mode_nxt;
            write_pulse  <= press_ev[WRITE_KEY];
        end
    end
endmodule

// File: tb/tb_key_event_proc.sv
// Bench for key_event_proc: directed scenarios plus random key activity, every
// cycle compared against a tick-counting behavioural model.
module tb_key_event_proc;
    localparam int NK = 4, CLK_HZ = 1000, SCAN_HZ = 100, DIV = CLK_HZ / SCAN_HZ;
    localparam int DB = 2, LT = 10, RT = 3, WK = 0, MW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_level, press_pulse, short_pulse, long_pulse, repeat_pulse;
    logic [MW-1:0] mode;
    logic          write_pulse;

    key_event_proc #(
        .NUM_KEYS(NK), .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_TICKS(DB),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT), .WRITE_KEY(WK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_level(key_level),
        .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .mode(mode), .write_pulse(write_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;

    // Model state: two-edge input delay, edges since reset, per-key stability and ticks held.
    logic [NK-1:0] dly1, dly2;
    int            tphase;
    int            stab[NK];
    int            held[NK];
    logic [NK-1:0] m_lvl, m_press, m_short, m_long, m_rep;
    logic [MW-1:0] m_mode;
    logic          m_write;

    int            n_press[NK], n_short[NK], n_long[NK], n_rep[NK], t_press[NK], t_last[NK];
    int            n_write, n_lvl_chg;
    logic          saw_simul;
    logic [NK-1:0] prev_lvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dly1 = '1; dly2 = '1; tphase = 0;
        for (int k = 0; k < NK; k++) begin stab[k] = 0; held[k] = -1; end
        m_lvl = '0; m_press = '0; m_short = '0; m_long = '0; m_rep = '0;
        m_mode = '0; m_write = 1'b0;
    endtask

    task automatic model_tick();
        logic [NK-1:0] sample;
        logic tk, rise, fall, found;
        sample = ~dly2;
        tk = (tphase % DIV) == DIV - 1;
        dly2 = dly1; dly1 = key_in; tphase++;
        m_press = '0; m_short = '0; m_long = '0; m_rep = '0;
        if (tk) begin
            for (int k = 0; k < NK; k++) begin
                rise = 1'b0; fall = 1'b0;
                if (sample[k] != m_lvl[k]) begin
                    stab[k]++;
                    if (stab[k] == DB) begin
                        stab[k] = 0; m_lvl[k] = sample[k];
                        rise = sample[k]; fall = !sample[k];
                    end
                end else stab[k] = 0;
                if (rise) begin
                    m_press[k] = 1'b1; held[k] = 0;
                end else if (fall) begin
                    if (held[k] < LT) m_short[k] = 1'b1;
                    held[k] = -1;
                end else if (held[k] >= 0) begin
                    held[k]++;
                    if (held[k] == LT) m_long[k] = 1'b1;
                    else if (held[k] > LT && (held[k] - LT) % RT == 0) m_rep[k] = 1'b1;
                end
            end
        end
        found = 1'b0;
        for (int i = 0; i < NK; i++)
            if (m_press[i] && !found) begin m_mode = MW'(i); found = 1'b1; end
        m_write = m_press[WK];
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            n_press[k] = 0; n_short[k] = 0; n_long[k] = 0; n_rep[k] = 0;
            t_press[k] = 0; t_last[k] = 0;
        end
        n_write = 0; n_lvl_chg = 0; saw_simul = 1'b0; prev_lvl = key_level;
    endtask

    task automatic tally();
        for (int k = 0; k < NK; k++) begin
            if (press_pulse[k]) begin n_press[k]++; t_press[k] = cyc; t_last[k] = cyc; end
            if (short_pulse[k]) n_short[k]++;
            if (long_pulse[k]) begin
                n_long[k]++;
                chk("long_latency", cyc - t_press[k], LT * DIV);
                t_last[k] = cyc;
            end
            if (repeat_pulse[k]) begin
                n_rep[k]++;
                chk("repeat_period", cyc - t_last[k], RT * DIV);
                t_last[k] = cyc;
            end
        end
        if (write_pulse) n_write++;
        if (key_level != prev_lvl) n_lvl_chg++;
        prev_lvl = key_level;
        if (press_pulse == 4'b1010) saw_simul = 1'b1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (rst_n) model_tick(); else model_reset();
            @(negedge clk);
            cyc++;
            chk("key_level", key_level, m_lvl);
            chk("press_pulse", press_pulse, m_press);
            chk("short_pulse", short_pulse, m_short);
            chk("long_pulse", long_pulse, m_long);
            chk("repeat_pulse", repeat_pulse, m_rep);
            chk("mode", mode, m_mode);
            chk("write_pulse", write_pulse, m_write);
            tally();
        end
    endtask

    task automatic wait_press(input int k, input int bound);
        int b;
        b = 0;
        while (n_press[k] == 0 && b < bound) begin step(1); b++; end
        chk("press_seen", n_press[k] > 0, 1);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_level"}, key_level, 0);
        chk({tag, "_pulses"}, {press_pulse, short_pulse, long_pulse, repeat_pulse, write_pulse}, 0);
        chk({tag, "_mode"}, mode, 0);
    endtask

    initial begin
        int b;
        // Reset values
        model_reset();
        repeat (3) @(negedge clk);
        zero_outputs("reset");
        rst_n = 1'b1;
        clear_counts();
        step(30);
        chk("reset_no_pulse", n_press[0] + n_press[1] + n_press[2] + n_press[3] + n_write, 0);

        // Short press on key 2
        clear_counts();
        key_in[2] = 1'b0; step(50);
        key_in[2] = 1'b1; step(40);
        chk("short_press_cnt", n_press[2], 1);
        chk("short_short_cnt", n_short[2], 1);
        chk("short_no_long", n_long[2], 0);
        chk("short_no_write", n_write, 0);
        chk("short_mode", mode, 2);

        // Long press with auto-repeat on key 0
        clear_counts();
        key_in[0] = 1'b0;
        wait_press(0, 40);
        step(LT * DIV + 3 * RT * DIV + 5);
        key_in[0] = 1'b1; step(40);
        chk("long_press_cnt", n_press[0], 1);
        chk("long_write_cnt", n_write, 1);
        chk("long_long_cnt", n_long[0], 1);
        chk("long_rep_cnt", n_rep[0], 3);
        chk("long_no_short", n_short[0], 0);
        chk("long_mode", mode, 0);

        // Bounce rejection on key 1: each low window spans exactly one tick
        clear_counts();
        for (int r = 0; r < 5; r++) begin
            b = 0;
            while (tphase % DIV != 2 && b < DIV) begin step(1); b++; end
            key_in[1] = 1'b0; step(12);
            key_in[1] = 1'b1; step(12);
        end
        step(30);
        chk("bounce_level_chg", n_lvl_chg, 0);
        chk("bounce_press", n_press[1], 0);
        chk("bounce_short", n_short[1], 0);

        // Simultaneous press of keys 3 and 1
        clear_counts();
        key_in = 4'b0101;
        wait_press(1, 40);
        step(5);
        chk("simul_seen", saw_simul, 1);
        chk("simul_press3", n_press[3], 1);
        chk("simul_mode", mode, 1);
        key_in = '1; step(40);

        // Asynchronous reset while key 3 is in LONG
        clear_counts();
        key_in[3] = 1'b0;
        b = 0;
        while (n_long[3] == 0 && b < 40 + LT * DIV) begin step(1); b++; end
        chk("arst_long_seen", n_long[3], 1);
        step(7);
        #2 rst_n = 1'b0;
        model_reset();
        #1 zero_outputs("arst");
        step(3);
        rst_n = 1'b1;
        clear_counts();
        wait_press(3, 40);
        step(20);
        chk("arst_repress", n_press[3], 1);
        chk("arst_no_short", n_short[3], 0);
        key_in = '1; step(40);

        // Random activity
        for (int r = 0; r < 40; r++) begin
            key_in = NK'($urandom);
            step($urandom_range(5, 160));
        end
        key_in = '1; step(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
